// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending-machine controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2
  } state_t;

  localparam int unsigned COIN5_VAL  = 5;
  localparam int unsigned COIN10_VAL = 10;

endpackage

// File: rtl/vend_fsm_core.sv
// Coin-accumulating vending controller: credits 5/10-unit coins and pulses
// dispense for one cycle whenever credit reaches PRICE. No change is returned.
module vend_fsm_core
  import vend_pkg::*;
#(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic coin_5,
  input  logic coin_10,
  output logic dispense
);

  localparam logic [CREDIT_W-1:0] PRICE_W  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] COIN5_W  = CREDIT_W'(COIN5_VAL);
  localparam logic [CREDIT_W-1:0] COIN10_W = CREDIT_W'(COIN10_VAL);
  localparam logic [CREDIT_W-1:0] ZERO_W   = {CREDIT_W{1'b0}};

  state_t              state_r;
  state_t              next_state_s;
  logic [CREDIT_W-1:0] credit_r;
  logic [CREDIT_W-1:0] next_credit_s;
  logic [CREDIT_W-1:0] add_s;
  logic [CREDIT_W-1:0] sum_s;
  logic                dispense_r;

  // Next-state and credit update; IDLE and VEND both start counting from zero.
  always_comb begin
    next_state_s  = state_r;
    next_credit_s = credit_r;
    add_s         = (coin_5 ? COIN5_W : ZERO_W) + (coin_10 ? COIN10_W : ZERO_W);
    sum_s         = credit_r + add_s;
    case (state_r)
      IDLE, VEND: begin
        if (add_s == ZERO_W) begin
          next_state_s  = IDLE;
          next_credit_s = ZERO_W;
        end else if (add_s >= PRICE_W) begin
          next_state_s  = VEND;
          next_credit_s = ZERO_W;
        end else begin
          next_state_s  = COLLECT;
          next_credit_s = add_s;
        end
      end
      COLLECT: begin
        if (add_s == ZERO_W) begin
          next_state_s  = COLLECT;
          next_credit_s = credit_r;
        end else if (sum_s >= PRICE_W) begin
          next_state_s  = VEND;
          next_credit_s = ZERO_W;
        end else begin
          next_state_s  = COLLECT;
          next_credit_s = sum_s;
        end
      end
      default: begin
        next_state_s  = IDLE;
        next_credit_s = ZERO_W;
      end
    endcase
  end

  // State, credit and dispense registers; dispense mirrors entry into VEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      credit_r   <= ZERO_W;
      dispense_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      credit_r   <= next_credit_s;
      dispense_r <= (next_state_s == VEND);
    end
  end

  assign dispense = dispense_r;

endmodule

// File: tb/tb_vend_fsm_core.sv
// Directed bench for vend_fsm_core with PRICE=15; expected values are hand-computed.
module tb_vend_fsm_core;

  logic clk;
  logic reset;
  logic coin_5;
  logic coin_10;
  logic dispense;

  int checks;
  int errors;
  int pulses;

  vend_fsm_core #(.PRICE(15), .CREDIT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .coin_5   (coin_5),
    .coin_10  (coin_10),
    .dispense (dispense)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge that took them.
  task automatic step(input logic r, input logic c5, input logic c10);
    reset   = r;
    coin_5  = c5;
    coin_10 = c10;
    @(posedge clk);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic r, input logic c5, input logic c10,
                          input int exp_disp, input int exp_credit);
    step(r, c5, c10);
    check_eq({tag, "_disp"}, int'(dispense), exp_disp);
    check_eq({tag, "_credit"}, int'(dut.credit_r), exp_credit);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; coin_5 = 1'b0; coin_10 = 1'b0;

    // Reset state
    step_chk("rst", 1'b1, 1'b0, 1'b0, 0, 0);

    // 5, idle, 10, idle -> vend after the 10
    step_chk("a_5",    1'b0, 1'b1, 1'b0, 0, 5);
    step_chk("a_idle", 1'b0, 1'b0, 1'b0, 0, 5);
    step_chk("a_10",   1'b0, 1'b0, 1'b1, 1, 0);
    step_chk("a_post", 1'b0, 1'b0, 1'b0, 0, 0);

    // 5,5,5 with idles -> vend only after the third
    step_chk("b_5a", 1'b0, 1'b1, 1'b0, 0, 5);
    step_chk("b_ia", 1'b0, 1'b0, 1'b0, 0, 5);
    step_chk("b_5b", 1'b0, 1'b1, 1'b0, 0, 10);
    step_chk("b_ib", 1'b0, 1'b0, 1'b0, 0, 10);
    step_chk("b_5c", 1'b0, 1'b1, 1'b0, 1, 0);
    step_chk("b_ic", 1'b0, 1'b0, 1'b0, 0, 0);

    // Back-to-back 5,10,5,5,5 -> two pulses; third coin credited from VEND
    pulses = 0;
    step_chk("c_5a", 1'b0, 1'b1, 1'b0, 0, 5);  pulses += int'(dispense);
    step_chk("c_10", 1'b0, 1'b0, 1'b1, 1, 0);  pulses += int'(dispense);
    step_chk("c_5b", 1'b0, 1'b1, 1'b0, 0, 5);  pulses += int'(dispense);
    step_chk("c_5c", 1'b0, 1'b1, 1'b0, 0, 10); pulses += int'(dispense);
    step_chk("c_5d", 1'b0, 1'b1, 1'b0, 1, 0);  pulses += int'(dispense);
    step_chk("c_end", 1'b0, 1'b0, 1'b0, 0, 0); pulses += int'(dispense);
    check_eq("c_pulses", pulses, 2);

    // Both coins at once from IDLE -> immediate vend; again from VEND -> back-to-back
    step_chk("d_both",  1'b0, 1'b1, 1'b1, 1, 0);
    step_chk("d_both2", 1'b0, 1'b1, 1'b1, 1, 0);
    step_chk("d_idle",  1'b0, 1'b0, 1'b0, 0, 0);

    // Overpayment 10+10 -> one vend, excess gone; a lone 5 then does not vend
    step_chk("e_10a", 1'b0, 1'b0, 1'b1, 0, 10);
    step_chk("e_10b", 1'b0, 1'b0, 1'b1, 1, 0);
    step_chk("e_5",   1'b0, 1'b1, 1'b0, 0, 5);
    step_chk("e_idl", 1'b0, 1'b0, 1'b0, 0, 5);
    step_chk("e_rst", 1'b1, 1'b0, 1'b0, 0, 0);

    // Reset with credit 10 (coin present, reset wins) -> following 5 does not vend
    step_chk("f_10",  1'b0, 1'b0, 1'b1, 0, 10);
    step_chk("f_rst", 1'b1, 1'b1, 1'b0, 0, 0);
    step_chk("f_5",   1'b0, 1'b1, 1'b0, 0, 5);
    step_chk("f_rs2", 1'b1, 1'b0, 1'b0, 0, 0);

    // Reset during VEND -> dispense low next cycle
    step_chk("g_10",  1'b0, 1'b0, 1'b1, 0, 10);
    step_chk("g_5",   1'b0, 1'b1, 1'b0, 1, 0);
    step_chk("g_rst", 1'b1, 1'b1, 1'b1, 0, 0);

    // coin_5 held three edges -> credited three times
    step_chk("h_h1", 1'b0, 1'b1, 1'b0, 0, 5);
    step_chk("h_h2", 1'b0, 1'b1, 1'b0, 0, 10);
    step_chk("h_h3", 1'b0, 1'b1, 1'b0, 1, 0);
    step_chk("h_rl", 1'b0, 1'b0, 1'b0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
